grf_wb_port: RTL and testbench
==============================

Name: grf_wb_port

Overview:
- 32 x 32-bit general register file (GRF) for the MIPS datapath.
- Write-back end of the register-address path: receives the 5-bit destination register number already chosen by the write-address 2:1 mux (rt/rd), plus write data and write enable.
- Decodes the destination one-hot and updates the selected register on the clock edge.
- Two asynchronous read ports feed the ALU and branch operands; a registered write-record port feeds the bench's commit log.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register-number width; register count = 2**ADDR_W.
- PC_W, 32, width of the PC tag carried into the write record.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- pc  in  PC_W  PC of the instruction performing write-back; used only for the write record.
- we  in  1  write enable from the controller.
- a1  in  ADDR_W  read port 1 register number (rs).
- a2  in  ADDR_W  read port 2 register number (rt).
- a3  in  ADDR_W  write register number (output of the write-address mux).
- wd  in  DATA_W  write data.
- rd1  out  DATA_W  read port 1 data.
- rd2  out  DATA_W  read port 2 data.
- wr_valid  out  1  pulses high for one cycle after each committed write.
- wr_pc  out  PC_W  pc of the committed write.
- wr_addr  out  ADDR_W  register number of the committed write.
- wr_data  out  DATA_W  value written.

Behaviour:
- Reset: when reset==0 at a rising edge, all 32 registers clear to 0 and wr_valid, wr_pc, wr_addr and wr_data clear to 0.
  - Reset wins over a simultaneous we: no write, no record.
  - A reset asserted mid-stream discards any write presented in that cycle.
- Write:
  - At a rising edge with reset==1, we==1 and a3!=0: reg[a3] <= wd, and the write record loads {1, pc, a3, wd}.
  - Latency: the new value is visible on rd1/rd2 in the cycle after the edge.
- Register $0:
  - Always reads 0.
  - A write with a3==0 changes no storage and produces no record (wr_valid==0 the next cycle).
- Record:
  - wr_valid==1 for exactly the cycle following each committed write.
  - Otherwise wr_valid==0; wr_pc, wr_addr and wr_data hold their last values.
- Read: rd1 = (a1==0) ? 0 : reg[a1]; rd2 likewise for a2. Purely combinational from a1/a2 and storage.
- Same-address reads: a1==a2 returns identical data on both ports.
- Write decode: a3 drives a 5-to-32 one-hot select gated by we. At most one register updates per cycle.
- No X propagation: all storage is reset, and reads of never-written registers return 0.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: internal write-to-read forwarding.
  - If we==1, a3!=0 and a1==a3 in the same cycle, rd1 = wd; likewise rd2 when a2==a3.
  - Reads therefore see the value being written this cycle, with zero-cycle latency.
  - $0 is still forced to 0.
  - Storage and write-record timing are unchanged.
- Not defined: reads return pre-edge storage; the new value appears only the cycle after the write.

Decomposition:
- Shared package grf_pkg:
  - constants GRF_ADDR_W=5, GRF_DATA_W=32, GRF_NUM=32, GRF_ZERO=5'd0;
  - typedef grf_addr_t (logic [4:0]);
  - typedef grf_data_t (logic [31:0]);
  - struct grf_wr_rec_t {valid, pc, addr, data}.
- One sub-module, grf_wr_decoder: a3 and we in, 32-bit one-hot write-select out, bit 0 forced low. It is the distribution counterpart to the write-address mux.

Test Plan:
- Reset: drive reset=0 for 2 cycles with we=1, a3=5, wd=32'hFFFF_FFFF -> rd1 (a1=5) == 0 and wr_valid==0 throughout; then release, a1=a2=31 -> rd1==rd2==0.
- Basic write/read: pc=32'h0000_3000, we=1, a3=8, wd=32'h1234_5678 for one cycle -> next cycle wr_valid==1, wr_pc==32'h0000_3000, wr_addr==8, wr_data==32'h1234_5678; a1=8 gives rd1==32'h1234_5678; the cycle after, wr_valid==0.
- $0 protection: we=1, a3=0, wd=32'hDEAD_BEEF -> a1=0 gives rd1==0; wr_valid stays 0.
- Back-to-back writes to all registers: write reg[i]=i*32'h0101_0101 for i=1..31 on consecutive cycles -> 31 consecutive wr_valid pulses with matching wr_addr; a sweep of a1/a2 returns each value and $0==0.
- Same-cycle read of a written register: reg[9]=32'h1; then we=1, a3=9, wd=32'h2, a1=9 -> rd1==32'h2 in that cycle with GRF_BYPASS_EN defined, ==32'h1 without it; 32'h2 in both builds the next cycle.
- Reset mid-stream: reg[4]=32'hA; drive reset=0 together with we=1, a3=4, wd=32'hB -> next cycle rd1 (a1=4)==0 and wr_valid==0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared types and constants for the general register file write-back port.
package grf_pkg;

   localparam int        GRF_ADDR_W = 5;
   localparam int        GRF_DATA_W = 32;
   localparam int        GRF_PC_W   = 32;
   localparam int        GRF_NUM    = 32;
   localparam logic [4:0] GRF_ZERO  = 5'd0;

   typedef logic [GRF_ADDR_W-1:0] grf_addr_t;
   typedef logic [GRF_DATA_W-1:0] grf_data_t;

   typedef struct packed {
      logic                valid;
      logic [GRF_PC_W-1:0] pc;
      grf_addr_t           addr;
      grf_data_t           data;
   } grf_wr_rec_t;

endpackage

// File: rtl/grf_wr_decoder.sv
// One-hot write-select fan-out for the register file; register 0 never selected.
module grf_wr_decoder #(
   parameter int ADDR_W = 5,
   parameter int NUM    = 2**ADDR_W
) (
   input  logic              we,
   input  logic [ADDR_W-1:0] a3,
   output logic [NUM-1:0]    wsel
);

   assign wsel[0] = 1'b0;

   for (genvar i = 1; i < NUM; i++) begin : g_sel
      assign wsel[i] = we && (a3 == ADDR_W'(i));
   end

endmodule

// File: rtl/grf_wb_port.sv
// 32x32 GRF with two async read ports and a registered write record.
// Define GRF_BYPASS_EN to forward same-cycle write data onto the read ports.
module grf_wb_port
   import grf_pkg::*;
#(
   parameter int DATA_W = GRF_DATA_W,
   parameter int ADDR_W = GRF_ADDR_W,
   parameter int PC_W   = GRF_PC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   pc,
   input  logic              we,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              wr_valid,
   output logic [PC_W-1:0]   wr_pc,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int NUM = 2**ADDR_W;

   logic [NUM-1:0][DATA_W-1:0] regs;
   logic [NUM-1:0]             wsel;
   grf_wr_rec_t                rec;

   grf_wr_decoder #(.ADDR_W(ADDR_W), .NUM(NUM)) u_dec (
      .we   (we),
      .a3   (a3),
      .wsel (wsel)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         regs <= '0;
         rec  <= '0;
      end else begin
         for (int i = 0; i < NUM; i++)
            if (wsel[i]) regs[i] <= wd;
         rec.valid <= |wsel;
         // record fields hold between commits
         if (|wsel) begin
            rec.pc   <= pc;
            rec.addr <= a3;
            rec.data <= wd;
         end
      end
   end

`ifdef GRF_BYPASS_EN
   // wsel already excludes $0 and qualifies with we, so it doubles as the hit test
   assign rd1 = (a1 == '0) ? '0 : (wsel[a1] ? wd : regs[a1]);
   assign rd2 = (a2 == '0) ? '0 : (wsel[a2] ? wd : regs[a2]);
`else
   assign rd1 = (a1 == '0) ? '0 : regs[a1];
   assign rd2 = (a2 == '0) ? '0 : regs[a2];
`endif

   assign wr_valid = rec.valid;
   assign wr_pc    = rec.pc;
   assign wr_addr  = rec.addr;
   assign wr_data  = rec.data;

endmodule

// File: tb/tb_grf_wb_port.sv
// Scoreboard bench for grf_wb_port: stimulus pushes expectations, a negedge monitor checks them.
module tb_grf_wb_port;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc = '0;
   logic        we = 1'b0;
   logic [4:0]  a1 = '0, a2 = '0, a3 = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd1, rd2;
   logic        wr_valid;
   logic [31:0] wr_pc;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   grf_wb_port dut (
      .clk(clk), .reset(reset), .pc(pc), .we(we), .a1(a1), .a2(a2), .a3(a3), .wd(wd),
      .rd1(rd1), .rd2(rd2), .wr_valid(wr_valid), .wr_pc(wr_pc), .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
      logic [4:0]  addr;
      logic [31:0] data;
   } rec_t;

   typedef struct {
      int          cyc;
      logic [31:0] e1;
      logic [31:0] e2;
   } rd_t;

   rec_t        rq[$];
   rd_t         dq[$];
   logic [31:0] model[32];
   int          cyc = 0;
   int          n_total = 0;
   int          n_pass = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] rd_exp(input logic [4:0] ra);
      if (ra == 5'd0) return 32'h0;
`ifdef GRF_BYPASS_EN
      if (we && a3 != 5'd0 && a3 == ra) return wd;
`endif
      return model[ra];
   endfunction

   // One cycle of stimulus; the model then advances past the following edge.
   task automatic drive(input logic r, input logic w, input logic [4:0] ad3,
                        input logic [31:0] d, input logic [31:0] p,
                        input logic [4:0] ad1, input logic [4:0] ad2);
      rd_t  e;
      rec_t c;
      @(posedge clk);
      #1;
      reset = r; we = w; a3 = ad3; wd = d; pc = p; a1 = ad1; a2 = ad2;
      e.cyc = cyc; e.e1 = rd_exp(ad1); e.e2 = rd_exp(ad2);
      dq.push_back(e);
      if (!r) begin
         foreach (model[i]) model[i] = 32'h0;
      end else if (w && ad3 != 5'd0) begin
         model[ad3] = d;
         c.cyc = cyc + 1; c.pc = p; c.addr = ad3; c.data = d;
         rq.push_back(c);
      end
   endtask

   // Monitor: decoupled from stimulus, driven purely by the queues.
   logic [31:0] last_pc = '0, last_data = '0;
   logic [4:0]  last_addr = '0;
   bit          clr = 0;

   always @(negedge clk) begin
      if (cyc >= 1) begin
         bit   ev;
         rec_t r;
         rd_t  e;
         if (clr) begin
            last_pc = '0; last_addr = '0; last_data = '0;
            clr = 0;
         end
         ev = (rq.size() > 0) && (rq[0].cyc == cyc);
         check("wr_valid", {31'h0, wr_valid}, {31'h0, ev});
         if (ev) begin
            r = rq.pop_front();
            if (wr_valid) begin
               check("wr_pc", wr_pc, r.pc);
               check("wr_addr", {27'h0, wr_addr}, {27'h0, r.addr});
               check("wr_data", wr_data, r.data);
            end
            last_pc = r.pc; last_addr = r.addr; last_data = r.data;
         end else if (!wr_valid) begin
            check("hold_pc", wr_pc, last_pc);
            check("hold_addr", {27'h0, wr_addr}, {27'h0, last_addr});
            check("hold_data", wr_data, last_data);
         end
         while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            e = dq.pop_front();
            check("rd1", rd1, e.e1);
            check("rd2", rd2, e.e2);
         end
         if (!reset) clr = 1;
      end
   end

   initial begin
      foreach (model[i]) model[i] = 32'h0;

      // reset held with a competing write
      drive(0, 1, 5'd5, 32'hFFFF_FFFF, 32'h0, 5'd5, 5'd5);
      drive(0, 1, 5'd5, 32'hFFFF_FFFF, 32'h0, 5'd5, 5'd5);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd31);

      // basic write / read-back
      drive(1, 1, 5'd8, 32'h1234_5678, 32'h0000_3000, 5'd8, 5'd0);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd8);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd1);

      // $0 protection
      drive(1, 1, 5'd0, 32'hDEAD_BEEF, 32'h0000_3004, 5'd0, 5'd0);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd8);

      // back-to-back writes to every register
      for (int i = 1; i < 32; i++)
         drive(1, 1, 5'(i), 32'(i) * 32'h0101_0101, 32'h4000 + 32'(4 * i),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      for (int i = 0; i < 32; i++)
         drive(1, 0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd17, 5'd17);

      // same-cycle read of the register being written
      drive(1, 1, 5'd9, 32'h1, 32'h5000, 5'd0, 5'd0);
      drive(1, 1, 5'd9, 32'h2, 32'h5004, 5'd9, 5'd9);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);

      // reset mid-stream discards the concurrent write
      drive(1, 1, 5'd4, 32'hA, 32'h6000, 5'd0, 5'd0);
      drive(0, 1, 5'd4, 32'hB, 32'h6004, 5'd4, 5'd4);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd9);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 31)), $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2);
      drive(1, 0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4);
      @(posedge clk);
      @(posedge clk);
      check("rec_q_drained", 32'(rq.size()), 32'h0);
      check("rd_q_drained", 32'(dq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
